ram_dual_be: RTL and testbench

//  Parametrised successor to the single-port data RAM: a word-addressed on-chip RAM with two ports.
//  - Port A is read-only, for instruction fetch.
//  - Port B is read/write with byte strobes, for load/store.
//  - Both ports use a req/ack handshake and return data registered, one cycle after the request.

---
 rtl/ram_dual_be_pkg.sv | 14 +
 rtl/ram_init_seq.sv | 50 +++++
 rtl/ram_dual_be.sv | 146 ++++++++++++++
 tb/tb_ram_dual_be.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dual_be_pkg.sv
// Shared constants and types for the dual-port byte-enable RAM.
// Imported by ram_dual_be and ram_init_seq.
package ram_dual_be_pkg;

    localparam int          BYTE_W    = 8;
    localparam int          RAM_DEPTH = 4096;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic {
        RAM_ST_IDLE  = 1'b0,
        RAM_ST_CLEAR = 1'b1
    } ram_st_e;

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sweep: walks every word once, requesting a zero write.
// Ports: clk, rst (sync, active-high); busy_o, clr_idx_o, clr_we_o.
module ram_init_seq
    import ram_dual_be_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy_o,
    output logic [IDX_W-1:0] clr_idx_o,
    output logic             clr_we_o
);

    ram_st_e          state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RAM_ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            RAM_ST_CLEAR: begin
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RAM_ST_IDLE;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign busy_o    = (state_q == RAM_ST_CLEAR);
    assign clr_idx_o = cnt_q;

endmodule

// File: rtl/ram_dual_be.sv
// Word-addressed RAM: port A read-only fetch, port B byte-strobed load/store.
// Both ports req/ack with registered data one cycle after accept; range and
// alignment errors ack with err=1. Optional clear sweep under RAM_CLR_EN.
// Ports: clk, rst, init_busy_o; a_req_i/a_addr_i -> a_ack_o/a_rdata_o/a_err_o;
// b_req_i/b_we_i/b_be_i/b_addr_i/b_wdata_i -> b_ack_o/b_rdata_o/b_err_o.
module ram_dual_be
    import ram_dual_be_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_busy_o,
    input  logic                       a_req_i,
    input  logic [ADDR_W-1:0]          a_addr_i,
    output logic                       a_ack_o,
    output logic [DATA_W-1:0]          a_rdata_o,
    output logic                       a_err_o,
    input  logic                       b_req_i,
    input  logic                       b_we_i,
    input  logic [DATA_W/BYTE_W-1:0]   b_be_i,
    input  logic [ADDR_W-1:0]          b_addr_i,
    input  logic [DATA_W-1:0]          b_wdata_i,
    output logic                       b_ack_o,
    output logic [DATA_W-1:0]          b_rdata_o,
    output logic                       b_err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic init_busy;

`ifdef RAM_CLR_EN
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;

    ram_init_seq #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .busy_o    (init_busy),
        .clr_idx_o (clr_idx),
        .clr_we_o  (clr_we)
    );
`else
    assign init_busy = 1'b0;
`endif

    assign init_busy_o = init_busy;

    // Word addresses; the range check uses all upper bits, not just the index.
    logic [ADDR_W-1:0] a_wa, b_wa;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic              a_err, b_err;

    assign a_wa  = a_addr_i >> 2;
    assign b_wa  = b_addr_i >> 2;
    assign a_idx = a_wa[IDX_W-1:0];
    assign b_idx = b_wa[IDX_W-1:0];
    assign a_err = (a_wa >= ADDR_W'(DEPTH));
    assign b_err = (b_wa >= ADDR_W'(DEPTH)) || (b_addr_i[1:0] != 2'b00);

    logic a_ack_q, b_ack_q, a_err_q, b_err_q;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic a_acc, b_acc, b_wr, a_fwd;
    logic [DATA_W-1:0] b_merged;

    // A port with an ack outstanding cannot accept, giving 1 access / 2 cycles.
    assign a_acc = a_req_i && !init_busy && !a_ack_q && !rst;
    assign b_acc = b_req_i && !init_busy && !b_ack_q && !rst;
    assign b_wr  = b_acc && b_we_i && !b_err;

    always_comb begin
        b_merged = mem_q[b_idx];
        for (int k = 0; k < BE_W; k++) begin
            if (b_be_i[k]) begin
                b_merged[k*BYTE_W +: BYTE_W] = b_wdata_i[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Write-first: a same-cycle A read of the word B writes sees the new word.
    assign a_fwd = b_wr && (a_idx == b_idx);

    always_comb begin
        a_rdata_d = '0;
        b_rdata_d = '0;
        if (!a_err) begin
            a_rdata_d = a_fwd ? b_merged : mem_q[a_idx];
        end
        if (!b_err && !b_we_i) begin
            b_rdata_d = mem_q[b_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_ack_q <= a_acc;
            b_ack_q <= b_acc;
            if (a_acc) begin
                a_err_q   <= a_err;
                a_rdata_q <= a_rdata_d;
            end
            if (b_acc) begin
                b_err_q   <= b_err;
                b_rdata_q <= b_rdata_d;
            end
        end
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
`ifdef RAM_CLR_EN
        if (clr_we) begin
            mem_q[clr_idx] <= '0;
        end else
`endif
        if (b_wr) begin
            mem_q[b_idx] <= b_merged;
        end
    end

    assign a_ack_o   = a_ack_q;
    assign a_err_o   = a_err_q;
    assign a_rdata_o = a_rdata_q;
    assign b_ack_o   = b_ack_q;
    assign b_err_o   = b_err_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: tb/tb_ram_dual_be.sv
// Directed bench for ram_dual_be (DEPTH=16): table of single transactions
// plus hand sequences for clear sweep, throughput and reset.
module tb_ram_dual_be;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          init_busy_o;
    logic          a_req_i;
    logic [AW-1:0] a_addr_i;
    logic          a_ack_o;
    logic [DW-1:0] a_rdata_o;
    logic          a_err_o;
    logic          b_req_i;
    logic          b_we_i;
    logic [3:0]    b_be_i;
    logic [AW-1:0] b_addr_i;
    logic [DW-1:0] b_wdata_i;
    logic          b_ack_o;
    logic [DW-1:0] b_rdata_o;
    logic          b_err_o;

    ram_dual_be #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_busy_o (init_busy_o),
        .a_req_i     (a_req_i),
        .a_addr_i    (a_addr_i),
        .a_ack_o     (a_ack_o),
        .a_rdata_o   (a_rdata_o),
        .a_err_o     (a_err_o),
        .b_req_i     (b_req_i),
        .b_we_i      (b_we_i),
        .b_be_i      (b_be_i),
        .b_addr_i    (b_addr_i),
        .b_wdata_i   (b_wdata_i),
        .b_ack_o     (b_ack_o),
        .b_rdata_o   (b_rdata_o),
        .b_err_o     (b_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_req;
        logic [31:0] a_addr;
        logic        b_req;
        logic        b_we;
        logic [3:0]  b_be;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        logic        a_err;
        logic [31:0] a_rdata;
        logic        b_err;
        logic [31:0] b_rdata;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic        ar,
        input logic [31:0] aa,
        input logic        br,
        input logic        bw,
        input logic [3:0]  be,
        input logic [31:0] ba,
        input logic [31:0] bd,
        input logic        ae,
        input logic [31:0] ad,
        input logic        bee,
        input logic [31:0] bdr
    );
        vec_t v;
        v.a_req   = ar;
        v.a_addr  = aa;
        v.b_req   = br;
        v.b_we    = bw;
        v.b_be    = be;
        v.b_addr  = ba;
        v.b_wdata = bd;
        v.a_err   = ae;
        v.a_rdata = ad;
        v.b_err   = bee;
        v.b_rdata = bdr;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        a_req_i   = 1'b0;
        a_addr_i  = '0;
        b_req_i   = 1'b0;
        b_we_i    = 1'b0;
        b_be_i    = '0;
        b_addr_i  = '0;
        b_wdata_i = '0;
    endtask

    // Counts cycles with busy high, starting from the current sample.
    task automatic sweep(input string nm, output int acks);
        int n;
        n    = 0;
        acks = 0;
        while (init_busy_o && n < 100) begin
            n++;
            if (a_ack_o) acks++;
            cyc();
        end
        chk(nm, 32'(n), 32'(DEPTH));
    endtask

    task automatic a_read(input string nm, input logic [31:0] addr,
                          input logic [31:0] exp);
        a_req_i  = 1'b1;
        a_addr_i = addr;
        cyc();
        chk({nm, " ack"}, {31'd0, a_ack_o}, 32'd1);
        chk({nm, " data"}, a_rdata_o, exp);
        idle();
        cyc();
    endtask

    initial begin
        int          acks;
        logic [9:0]  pat;
        vec_t        v;

        idle();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst a_ack", {31'd0, a_ack_o}, 32'd0);
        chk("rst b_ack", {31'd0, b_ack_o}, 32'd0);
        chk("rst a_rdata", a_rdata_o, 32'd0);
        chk("rst b_rdata", b_rdata_o, 32'd0);
        chk("rst a_err", {31'd0, a_err_o}, 32'd0);
        chk("rst b_err", {31'd0, b_err_o}, 32'd0);
`ifdef RAM_CLR_EN
        chk("rst busy", {31'd0, init_busy_o}, 32'd1);
        // Requester holds req through the sweep; it must wait.
        a_req_i  = 1'b1;
        a_addr_i = 32'h0;
        rst      = 1'b0;
        sweep("sweep len", acks);
        chk("sweep acks", 32'(acks), 32'd0);
        chk("post sweep ack", {31'd0, a_ack_o}, 32'd0);
        cyc();
        chk("first ack", {31'd0, a_ack_o}, 32'd1);
        chk("first data", a_rdata_o, 32'd0);
        idle();
        cyc();
        for (int w = 0; w < DEPTH; w++) begin
            a_read($sformatf("clr w%0d", w), 32'(w * 4), 32'd0);
        end
`else
        chk("rst busy", {31'd0, init_busy_o}, 32'd0);
        rst = 1'b0;
        cyc();
`endif

        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'h2, 32'h8, 32'h0000AA00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 32'h8, 0, 0, 0, 0, 32'hDEADAAEF));
        tbl.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 0, 32'hDEADAAEF, 0, 0));
        tbl.push_back(mk(1, 32'h4, 1, 1, 4'hF, 32'h4, 32'h12345678,
                         0, 32'h12345678, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 32'h4, 0, 0, 0, 0, 32'h12345678));
        tbl.push_back(mk(0, 0, 1, 1, 4'h0, 32'h4, 32'hFFFFFFFF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0, 0, 32'h12345678, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 32'h6, 32'h0BADBEEF, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 32'h4, 0, 0, 0, 0, 32'h12345678));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 32'h40, 32'h11111111, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
        tbl.push_back(mk(1, 32'h0, 1, 0, 4'h0, 32'h42, 0,
                         0, 32'hCAFEF00D, 1, 32'h0));
        tbl.push_back(mk(1, 32'h2, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(1, 32'h8, 1, 1, 4'h8, 32'h8, 32'h11000000,
                         0, 32'h11ADAAEF, 0, 0));
        tbl.push_back(mk(1, 32'h8, 1, 0, 4'h0, 32'h8, 0,
                         0, 32'h11ADAAEF, 0, 32'h11ADAAEF));
        tbl.push_back(mk(0, 0, 1, 1, 4'hF, 32'h3C, 32'hA5A5A5A5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h3C, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            v         = tbl[i];
            a_req_i   = v.a_req;
            a_addr_i  = v.a_addr;
            b_req_i   = v.b_req;
            b_we_i    = v.b_we;
            b_be_i    = v.b_be;
            b_addr_i  = v.b_addr;
            b_wdata_i = v.b_wdata;
            cyc();
            chk($sformatf("v%0d a_ack", i), {31'd0, a_ack_o},
                {31'd0, v.a_req});
            chk($sformatf("v%0d b_ack", i), {31'd0, b_ack_o},
                {31'd0, v.b_req});
            if (v.a_req) begin
                chk($sformatf("v%0d a_err", i), {31'd0, a_err_o},
                    {31'd0, v.a_err});
                chk($sformatf("v%0d a_rdata", i), a_rdata_o, v.a_rdata);
            end
            if (v.b_req) begin
                chk($sformatf("v%0d b_err", i), {31'd0, b_err_o},
                    {31'd0, v.b_err});
                if (!v.b_we) begin
                    chk($sformatf("v%0d b_rdata", i), b_rdata_o, v.b_rdata);
                end
            end
            idle();
            cyc();
            chk($sformatf("v%0d ack drop", i), {30'd0, a_ack_o, b_ack_o},
                32'd0);
        end

        // Held request: acks on every other cycle.
        a_req_i  = 1'b1;
        a_addr_i = 32'h4;
        pat      = '0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            pat[c] = a_ack_o;
        end
        chk("held ack pattern", {22'd0, pat}, {22'd0, 10'b0101010101});
        idle();
        cyc();

        // Reset with an ack in flight.
        a_req_i  = 1'b1;
        a_addr_i = 32'h8;
        cyc();
        chk("pre-rst ack", {31'd0, a_ack_o}, 32'd1);
        chk("pre-rst data", a_rdata_o, 32'h11ADAAEF);
        idle();
        rst = 1'b1;
        cyc();
        chk("mid-rst ack", {31'd0, a_ack_o}, 32'd0);
        chk("mid-rst data", a_rdata_o, 32'd0);
        rst = 1'b0;
`ifdef RAM_CLR_EN
        for (int c = 0; c < 5; c++) cyc();
        chk("mid-sweep busy", {31'd0, init_busy_o}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sweep("resweep len", acks);
        a_read("cleared w2", 32'h8, 32'd0);
`else
        cyc();
        a_read("kept w2", 32'h8, 32'h11ADAAEF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
